// File: rtl/store_fwd_queue_if.sv
// Bus between the 6502 core, the store queue and the slow target.
// Includes the store request, head drain handshake, load lookup and status.
interface store_fwd_queue_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 128
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic [ADDR_W-1:0] lk_addr;
    logic              lk_hit;
    logic [DATA_W-1:0] lk_data;
    logic              ovf_clr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              afull;
    logic              overflow;

    modport master (
        output wr_en, wr_data, wr_addr, out_ready, lk_addr, ovf_clr,
        input  out_valid, out_data, out_addr, lk_hit, lk_data, count, full, empty, afull,
               overflow
    );

    modport slave (
        input  wr_en, wr_data, wr_addr, out_ready, lk_addr, ovf_clr,
        output out_valid, out_data, out_addr, lk_hit, lk_data, count, full, empty, afull,
               overflow
    );
endinterface

// File: rtl/store_fwd_queue.sv
// In-order store write-buffer with handshaked drain, overflow status and, when
// STORE_FWD_EN is defined, youngest-match store-to-load forwarding.
module store_fwd_queue #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned AFULL_LVL = DEPTH - 4,
    parameter int unsigned EDGE_WR   = 1
) (
    input logic               clk,
    input logic               rst_n,
    store_fwd_queue_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              wr_en_q;

    logic empty, full, wr_fire, pop, push, drop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign wr_fire = (EDGE_WR != 0) ? (bus.wr_en & ~wr_en_q) : bus.wr_en;
    assign pop     = bus.out_ready & ~empty;
    // A full queue still accepts a store when the head leaves in the same cycle.
    assign push    = wr_fire & (~full | pop);
    assign drop    = wr_fire & full & ~bus.out_ready;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        overflow_d = overflow_q;
        if (bus.ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            wr_en_q    <= 1'b0;
        end else begin
            if (push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            count_q    <= count_d;
            overflow_q <= overflow_d;
            wr_en_q    <= bus.wr_en;
        end
    end

    // Storage is deliberately left unreset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[tail_q] <= bus.wr_data;
            addr_mem_q[tail_q] <= bus.wr_addr;
        end
    end

    assign bus.out_valid = ~empty;
    assign bus.out_data  = empty ? '0 : data_mem_q[head_q];
    assign bus.out_addr  = empty ? '0 : addr_mem_q[head_q];
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.afull     = (count_q >= CNT_W'(AFULL_LVL));
    assign bus.overflow  = overflow_q;

`ifdef STORE_FWD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        bus.lk_hit  = 1'b0;
        bus.lk_data = '0;
        fwd_idx     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_mem_q[fwd_idx] == bus.lk_addr)) begin
                bus.lk_hit  = 1'b1;
                bus.lk_data = data_mem_q[fwd_idx];
            end
        end
    end
`else
    assign bus.lk_hit  = 1'b0;
    assign bus.lk_data = '0;
`endif
endmodule

// File: tb/tb_store_fwd_queue.sv
// Randomised and directed bench for store_fwd_queue: two DEPTH=4 instances
// (edge-capture and level-capture) checked every cycle against a queue model.
module tb_store_fwd_queue;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;
    bit chk_en = 1'b0;

    // Per-instance drive: index 0 = EDGE_WR=1, index 1 = EDGE_WR=0.
    logic [1:0]  s_wr_en, s_out_ready, s_ovf_clr;
    logic [7:0]  s_wr_data [2];
    logic [15:0] s_wr_addr [2];
    logic [15:0] s_lk_addr [2];

    logic [1:0]  o_valid, o_full, o_empty, o_afull, o_ovf, o_hit;
    logic [7:0]  o_data [2];
    logic [7:0]  o_lk_data [2];
    logic [15:0] o_addr [2];
    logic [2:0]  o_count [2];

    store_fwd_queue_if #(.DATA_W(8), .ADDR_W(16), .DEPTH(D)) if_e ();
    store_fwd_queue_if #(.DATA_W(8), .ADDR_W(16), .DEPTH(D)) if_l ();

    store_fwd_queue #(.DATA_W(8), .ADDR_W(16), .DEPTH(D), .AFULL_LVL(3), .EDGE_WR(1)) dut_e (
        .clk(clk), .rst_n(rst_n), .bus(if_e)
    );
    store_fwd_queue #(.DATA_W(8), .ADDR_W(16), .DEPTH(D), .AFULL_LVL(3), .EDGE_WR(0)) dut_l (
        .clk(clk), .rst_n(rst_n), .bus(if_l)
    );

    assign if_e.wr_en = s_wr_en[0];         assign if_l.wr_en = s_wr_en[1];
    assign if_e.wr_data = s_wr_data[0];     assign if_l.wr_data = s_wr_data[1];
    assign if_e.wr_addr = s_wr_addr[0];     assign if_l.wr_addr = s_wr_addr[1];
    assign if_e.out_ready = s_out_ready[0]; assign if_l.out_ready = s_out_ready[1];
    assign if_e.lk_addr = s_lk_addr[0];     assign if_l.lk_addr = s_lk_addr[1];
    assign if_e.ovf_clr = s_ovf_clr[0];     assign if_l.ovf_clr = s_ovf_clr[1];

    assign o_valid = {if_l.out_valid, if_e.out_valid};
    assign o_full  = {if_l.full, if_e.full};
    assign o_empty = {if_l.empty, if_e.empty};
    assign o_afull = {if_l.afull, if_e.afull};
    assign o_ovf   = {if_l.overflow, if_e.overflow};
    assign o_hit   = {if_l.lk_hit, if_e.lk_hit};
    assign o_data[0] = if_e.out_data;       assign o_data[1] = if_l.out_data;
    assign o_addr[0] = if_e.out_addr;       assign o_addr[1] = if_l.out_addr;
    assign o_lk_data[0] = if_e.lk_data;     assign o_lk_data[1] = if_l.lk_data;
    assign o_count[0] = if_e.count;         assign o_count[1] = if_l.count;

    // Model: entries kept oldest-first in a shifting array.
    logic [23:0] m_ent [2][D];
    int          m_cnt [2] = '{0, 0};
    logic        m_ovf [2] = '{1'b0, 1'b0};
    logic        m_prev [2] = '{1'b0, 1'b0};

    task automatic chk(input string nm, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s dut%0d got=%0h exp=%0h t=%0t", nm, d, act, exp, $time);
        end
    endtask

    task automatic check_dut(input int d);
        logic       eh;
        logic [7:0] ed;
        eh = 1'b0;
        ed = 8'h00;
`ifdef STORE_FWD_EN
        for (int k = 0; k < m_cnt[d]; k++) begin
            if (m_ent[d][k][23:8] == s_lk_addr[d]) begin
                eh = 1'b1;
                ed = m_ent[d][k][7:0];
            end
        end
`endif
        chk("count", d, 32'(o_count[d]), 32'(m_cnt[d]));
        chk("empty", d, 32'(o_empty[d]), 32'(m_cnt[d] == 0));
        chk("full", d, 32'(o_full[d]), 32'(m_cnt[d] == D));
        chk("afull", d, 32'(o_afull[d]), 32'(m_cnt[d] >= 3));
        chk("out_valid", d, 32'(o_valid[d]), 32'(m_cnt[d] != 0));
        chk("out_data", d, 32'(o_data[d]), (m_cnt[d] != 0) ? 32'(m_ent[d][0][7:0]) : 32'd0);
        chk("out_addr", d, 32'(o_addr[d]), (m_cnt[d] != 0) ? 32'(m_ent[d][0][23:8]) : 32'd0);
        chk("overflow", d, 32'(o_ovf[d]), 32'(m_ovf[d]));
        chk("lk_hit", d, 32'(o_hit[d]), 32'(eh));
        chk("lk_data", d, 32'(o_lk_data[d]), 32'(ed));
    endtask

    task automatic model_step();
        logic fire, pop, was_full;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_cnt[d]  = 0;
                m_ovf[d]  = 1'b0;
                m_prev[d] = 1'b0;
            end else begin
                fire      = (d == 0) ? (s_wr_en[d] && !m_prev[d]) : s_wr_en[d];
                m_prev[d] = s_wr_en[d];
                was_full  = (m_cnt[d] == D);
                pop       = s_out_ready[d] && (m_cnt[d] > 0);
                if (pop) begin
                    for (int k = 0; k < D - 1; k++) m_ent[d][k] = m_ent[d][k+1];
                    m_cnt[d]--;
                end
                if (s_ovf_clr[d]) m_ovf[d] = 1'b0;
                if (fire) begin
                    if (!was_full || pop) begin
                        m_ent[d][m_cnt[d]] = {s_wr_addr[d], s_wr_data[d]};
                        m_cnt[d]++;
                    end else begin
                        m_ovf[d] = 1'b1;
                    end
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check_dut(0);
                check_dut(1);
            end
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_l(input logic [15:0] a, input logic [7:0] v);
        s_wr_en[1] = 1'b1;
        s_wr_addr[1] = a;
        s_wr_data[1] = v;
        tick();
        s_wr_en[1] = 1'b0;
    endtask

    initial begin
        s_wr_en = '0; s_out_ready = '0; s_ovf_clr = '0;
        for (int d = 0; d < 2; d++) begin
            s_wr_data[d] = '0; s_wr_addr[d] = '0; s_lk_addr[d] = '0;
        end

        // Edge capture: wr_en held high across reset release gives one push.
        s_wr_en[0] = 1'b1; s_wr_data[0] = 8'h11; s_wr_addr[0] = 16'h2000;
        tick();
        chk_en = 1'b1;
        rst_n = 1'b1;
        repeat (5) tick();
        chk("edge_count", 0, 32'(o_count[0]), 32'd1);
        chk("edge_data", 0, 32'(o_data[0]), 32'h11);
        chk("edge_addr", 0, 32'(o_addr[0]), 32'h2000);
        s_wr_en[0] = 1'b0;

        // Level capture: fill, overflow, drain in order.
        for (int i = 0; i < 4; i++) begin
            push_l(16'h3000 + 16'(i), 8'hA0 + 8'(i));
            chk("fill_afull", 1, 32'(o_afull[1]), 32'(i >= 2));
            chk("fill_full", 1, 32'(o_full[1]), 32'(i == 3));
        end
        push_l(16'h3004, 8'hA4);
        chk("drop_ovf", 1, 32'(o_ovf[1]), 32'd1);
        chk("drop_count", 1, 32'(o_count[1]), 32'd4);
        s_out_ready[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", 1, 32'(o_data[1]), 32'hA0 + 32'(i));
            tick();
        end
        s_out_ready[1] = 1'b0;
        chk("drain_empty", 1, 32'(o_empty[1]), 32'd1);
        chk("drain_zero", 1, 32'(o_data[1]), 32'd0);
        s_ovf_clr[1] = 1'b1; tick(); s_ovf_clr[1] = 1'b0;
        chk("ovf_clr", 1, 32'(o_ovf[1]), 32'd0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 4; i++) push_l(16'h3100, 8'hB0 + 8'(i));
        s_out_ready[1] = 1'b1;
        push_l(16'h3100, 8'hB4);
        chk("fullpp_count", 1, 32'(o_count[1]), 32'd4);
        chk("fullpp_ovf", 1, 32'(o_ovf[1]), 32'd0);
        repeat (3) tick();
        chk("fullpp_last", 1, 32'(o_data[1]), 32'hB4);
        tick();
        s_out_ready[1] = 1'b0;

        // Forwarding: youngest matching store wins.
        push_l(16'h1808, 8'h05);
        push_l(16'h1808, 8'h07);
        s_lk_addr[1] = 16'h1808; #1;
`ifdef STORE_FWD_EN
        chk("fwd_hit", 1, 32'(o_hit[1]), 32'd1);
        chk("fwd_data", 1, 32'(o_lk_data[1]), 32'h07);
`else
        chk("fwd_hit_off", 1, 32'(o_hit[1]), 32'd0);
        chk("fwd_data_off", 1, 32'(o_lk_data[1]), 32'h00);
`endif
        s_lk_addr[1] = 16'h1810; #1;
        chk("fwd_miss", 1, 32'(o_hit[1]), 32'd0);
        s_lk_addr[1] = 16'h1808;
        s_out_ready[1] = 1'b1; tick(); tick(); s_out_ready[1] = 1'b0;
        chk("fwd_popped", 1, 32'(o_hit[1]), 32'd0);

        // Wrap: push/pop pairs, first cycle sees an empty queue.
        s_out_ready[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_wr_en[1] = 1'b1; s_wr_addr[1] = 16'h4000 + 16'(i); s_wr_data[1] = 8'hC0 + 8'(i);
            tick();
        end
        s_wr_en[1] = 1'b0; s_out_ready[1] = 1'b0;
        chk("wrap_count", 1, 32'(o_count[1]), 32'd1);
        chk("wrap_data", 1, 32'(o_data[1]), 32'hC9);

        // Reset with entries queued and overflow set.
        for (int i = 0; i < 4; i++) push_l(16'h5000, 8'hD0 + 8'(i));
        s_out_ready[1] = 1'b1; push_l(16'h5000, 8'hDF);
        s_out_ready[1] = 1'b0;
        push_l(16'h5000, 8'hEE);
        s_out_ready[1] = 1'b1; tick(); s_out_ready[1] = 1'b0;
        chk("prerst_count", 1, 32'(o_count[1]), 32'd3);
        chk("prerst_ovf", 1, 32'(o_ovf[1]), 32'd1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("rst_count", 1, 32'(o_count[1]), 32'd0);
        chk("rst_empty", 1, 32'(o_empty[1]), 32'd1);
        chk("rst_ovf", 1, 32'(o_ovf[1]), 32'd0);
        chk("rst_valid", 1, 32'(o_valid[1]), 32'd0);

        // Random traffic on both instances; model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            for (int d = 0; d < 2; d++) begin
                s_wr_en[d]     = ($urandom_range(0, 2) != 0);
                s_out_ready[d] = ($urandom_range(0, 2) == 0);
                s_ovf_clr[d]   = ($urandom_range(0, 15) == 0);
                s_wr_data[d]   = 8'($urandom);
                s_wr_addr[d]   = 16'h1800 + 16'($urandom_range(0, 3));
                s_lk_addr[d]   = 16'h1800 + 16'($urandom_range(0, 3));
            end
            tick();
        end
        rst_n = 1'b1;
        s_wr_en = '0; s_out_ready = '0; s_ovf_clr = '0;
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
